// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// cache_pkg : shared types and default geometry for the data cache | rev 1.0
// ============================================================================
package cache_pkg;

  localparam int unsigned c_DATA_WIDTH     = 32;
  localparam int unsigned c_SETS           = 64;
  localparam int unsigned c_WORDS_PER_LINE = 4;
  localparam int unsigned c_IDX_W          = $clog2(c_SETS);
  localparam int unsigned c_OFF_W          = $clog2(c_WORDS_PER_LINE);
  localparam int unsigned c_TAG_W          = c_DATA_WIDTH - c_IDX_W - c_OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2
  } cache_state_e;

  typedef struct packed {
    logic                                               valid;
    logic                                               dirty;
    logic [c_TAG_W-1:0]                                 tag;
    logic [c_WORDS_PER_LINE-1:0][c_DATA_WIDTH-1:0]      data;
  } cache_line_t;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_line_store.sv
`default_nettype none
// ============================================================================
// cache_line_store : tag/valid/dirty/data arrays, async read, sync write | rev 1.0
// ============================================================================
module cache_line_store
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = c_DATA_WIDTH,
  parameter int unsigned SETS           = c_SETS,
  parameter int unsigned WORDS_PER_LINE = c_WORDS_PER_LINE,
  parameter int unsigned TAG_W          = c_TAG_W
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [$clog2(SETS)-1:0]                    rd_idx_i,
  output logic                                       rd_valid_o,
  output logic                                       rd_dirty_o,
  output logic [TAG_W-1:0]                           rd_tag_o,
  output logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0]  rd_data_o,
  input  logic [$clog2(SETS)-1:0]                    wr_idx_i,
  input  logic [WORDS_PER_LINE-1:0]                  wr_word_en_i,
  input  logic [DATA_WIDTH/8-1:0]                    wr_be_i,
  input  logic [DATA_WIDTH-1:0]                      wr_data_i,
  input  logic                                       meta_we_i,
  input  logic [TAG_W-1:0]                           wr_tag_i,
  input  logic                                       wr_valid_i,
  input  logic                                       wr_dirty_i
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic [SETS-1:0]                           valid_q;
  logic [SETS-1:0]                           dirty_q;
  logic [TAG_W-1:0]                          tag_q  [SETS];
  logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] data_q [SETS];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
      dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  // Payload arrays carry no reset; contents are meaningless until valid is set.
  always_ff @(posedge clk_i) begin
    if (meta_we_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_word_en_i[w] && wr_be_i[b]) begin
          data_q[wr_idx_i][w][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

endmodule : cache_line_store
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// data_cache : direct-mapped write-back/write-allocate D-cache, miss FSM | rev 1.0
// ============================================================================
module data_cache
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = c_DATA_WIDTH,
  parameter int unsigned SETS           = c_SETS,
  parameter int unsigned WORDS_PER_LINE = c_WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  input  logic                  we,
  input  logic                  byte_addr,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned TAG_W = DATA_WIDTH - IDX_W - OFF_W - 2;
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  cache_state_e     state_q, state_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic             retry_q, retry_d;
  logic [31:0]      hit_cnt_q, hit_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]                          w_idx;
  logic [OFF_W-1:0]                          w_word;
  logic [TAG_W-1:0]                          w_tag;
  logic                                      w_access;
  logic                                      w_hit;
  logic                                      w_line_valid;
  logic                                      w_line_dirty;
  logic [TAG_W-1:0]                          w_line_tag;
  logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] w_line_data;
  logic [DATA_WIDTH-1:0]                     w_lane_shifted;

  cache_state_e                              w_xfer;
  logic [OFF_W-1:0]                          w_beat;
  logic [WORDS_PER_LINE-1:0]                 w_wr_word_en;
  logic [BE_W-1:0]                           w_wr_be;
  logic [DATA_WIDTH-1:0]                     w_wr_data;
  logic                                      w_meta_we;
  logic [TAG_W-1:0]                          w_wr_tag;
  logic                                      w_wr_valid;
  logic                                      w_wr_dirty;

  assign w_idx    = addr[2+OFF_W +: IDX_W];
  assign w_word   = addr[2 +: OFF_W];
  assign w_tag    = addr[DATA_WIDTH-1 -: TAG_W];
  assign w_access = re | we;
  assign w_hit    = w_line_valid && (w_line_tag == w_tag);
  assign w_lane_shifted = w_line_data[w_word] >> {addr[1:0], 3'b000};

  cache_line_store #(
    .DATA_WIDTH     (DATA_WIDTH),
    .SETS           (SETS),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W)
  ) u_store (
    .clk_i        (clk),
    .rst_ni       (rst),
    .rd_idx_i     (w_idx),
    .rd_valid_o   (w_line_valid),
    .rd_dirty_o   (w_line_dirty),
    .rd_tag_o     (w_line_tag),
    .rd_data_o    (w_line_data),
    .wr_idx_i     (w_idx),
    .wr_word_en_i (w_wr_word_en),
    .wr_be_i      (w_wr_be),
    .wr_data_i    (w_wr_data),
    .meta_we_i    (w_meta_we),
    .wr_tag_i     (w_wr_tag),
    .wr_valid_i   (w_wr_valid),
    .wr_dirty_i   (w_wr_dirty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      retry_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      retry_q    <= retry_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    retry_d      = retry_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    rdata        = '0;
    w_wr_word_en = '0;
    w_wr_be      = '0;
    w_wr_data    = '0;
    w_meta_we    = 1'b0;
    w_wr_tag     = w_line_tag;
    w_wr_valid   = 1'b0;
    w_wr_dirty   = 1'b0;
    w_xfer       = state_q;
    w_beat       = beat_q;

    if (state_q == IDLE) begin
      retry_d = 1'b0;
      w_xfer  = IDLE;
      w_beat  = '0;
      if (w_access) begin
        if (w_hit) begin
          if (!retry_q) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
          end
          if (we) begin
            w_wr_word_en[w_word] = 1'b1;
            w_wr_be    = byte_addr ? (BE_W'(1) << addr[1:0]) : '1;
            w_wr_data  = byte_addr ? {BE_W{wdata[7:0]}} : wdata;
            w_meta_we  = 1'b1;
            w_wr_valid = 1'b1;
            w_wr_dirty = 1'b1;
          end else begin
            rdata = byte_addr ? {{(DATA_WIDTH-8){1'b0}}, w_lane_shifted[7:0]}
                              : w_line_data[w_word];
          end
        end else begin
          // Beat 0 is issued in the miss cycle itself so the penalty carries no extra cycle.
          stall      = 1'b1;
          miss_cnt_d = miss_cnt_q + 32'd1;
          w_xfer     = (w_line_valid && w_line_dirty) ? WB : REFILL;
          state_d    = w_xfer;
          beat_d     = '0;
        end
      end
    end

    case (w_xfer)
      WB: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {w_line_tag, w_idx, w_beat, 2'b00};
        mem_wdata = w_line_data[w_beat];
        if (mem_ready) begin
          if (w_beat == LAST_BEAT) begin
            state_d = REFILL;
            beat_d  = '0;
          end else begin
            beat_d = w_beat + 1'b1;
          end
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_idx, w_beat, 2'b00};
        if (mem_ready) begin
          w_wr_word_en[w_beat] = 1'b1;
          w_wr_be   = '1;
          w_wr_data = mem_rdata;
          if (w_beat == LAST_BEAT) begin
            w_meta_we  = 1'b1;
            w_wr_tag   = w_tag;
            w_wr_valid = 1'b1;
            w_wr_dirty = 1'b0;
            retry_d    = 1'b1;
            state_d    = IDLE;
            beat_d     = '0;
          end else begin
            beat_d = w_beat + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule : data_cache
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// tb_data_cache : randomized self-checking bench with reference cache model | rev 1.0
// ============================================================================
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we, byte_addr;
  logic [31:0] addr, wdata, rdata;
  logic        stall;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  data_cache dut (
    .clk        (clk),
    .rst        (rst),
    .re         (re),
    .we         (we),
    .byte_addr  (byte_addr),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Backing memory served to the DUT, and the model's independent copy of it.
  logic [31:0] bk_mem  [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] bk_read(input logic [31:0] a);
    return bk_mem.exists(a) ? bk_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t act_q[$];
  beat_t exp_q[$];

  int          wait_mode = 0;
  logic        hold_en   = 1'b0;
  logic [31:0] hold_addr = '0;
  int          req_cycles = 0;
  bit          pending = 1'b0;
  int          rem = 0;
  beat_t       lat;

  // Memory responder: random or fixed wait states, checks handshake stability.
  always @(negedge clk) begin
    #2;
    if (mem_req !== 1'b1) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      pending   = 1'b0;
    end else begin
      req_cycles++;
      if (!pending) begin
        pending = 1'b1;
        lat = '{we: mem_we, addr: mem_addr, data: mem_wdata};
        if (hold_en && mem_addr == hold_addr) rem = 5;
        else if (wait_mode >= 0)              rem = wait_mode;
        else                                  rem = int'($urandom_range(0, 3));
      end else begin
        check_eq("hs_addr",  mem_addr,  lat.addr);
        check_eq("hs_we",    32'(mem_we), 32'(lat.we));
        check_eq("hs_wdata", mem_wdata, lat.data);
      end
      if (rem > 0) begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        rem--;
      end else begin
        mem_ready = 1'b1;
        pending   = 1'b0;
        if (mem_we) begin
          bk_mem[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
          act_q.push_back('{we: 1'b1, addr: mem_addr, data: mem_wdata});
        end else begin
          mem_rdata = bk_read(mem_addr);
          act_q.push_back('{we: 1'b0, addr: mem_addr, data: mem_rdata});
        end
      end
    end
  end

  // Reference model: one entry per set, whole-line fill/evict per access.
  bit          m_valid [64];
  bit          m_dirty [64];
  logic [21:0] m_tag   [64];
  logic [31:0] m_data  [64][4];
  int          exp_hits = 0;
  int          exp_miss = 0;

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
    exp_hits = 0;
    exp_miss = 0;
  endtask

  task automatic model_access(input bit w, input bit b, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] rd, output bit hit);
    int          idx, wd, ln;
    logic [21:0] tg;
    logic [31:0] ba;
    idx = int'(a[9:4]);
    wd  = int'(a[3:2]);
    ln  = int'(a[1:0]);
    tg  = a[31:10];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (hit) begin
      exp_hits++;
    end else begin
      exp_miss++;
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int i = 0; i < 4; i++) begin
          ba = {m_tag[idx], a[9:4], 2'(i), 2'b00};
          ref_mem[ba] = m_data[idx][i];
          exp_q.push_back('{we: 1'b1, addr: ba, data: m_data[idx][i]});
        end
      end
      for (int i = 0; i < 4; i++) begin
        ba = {tg, a[9:4], 2'(i), 2'b00};
        m_data[idx][i] = ref_read(ba);
        exp_q.push_back('{we: 1'b0, addr: ba, data: m_data[idx][i]});
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    rd = '0;
    if (w) begin
      if (b) m_data[idx][wd][8*ln +: 8] = d[7:0];
      else   m_data[idx][wd] = d;
      m_dirty[idx] = 1'b1;
    end else begin
      rd = b ? {24'h0, m_data[idx][wd][8*ln +: 8]} : m_data[idx][wd];
    end
  endtask

  task automatic do_access(input bit r, input bit w, input bit b, input logic [31:0] a,
                           input logic [31:0] d, output int stall_cyc);
    logic [31:0] erd;
    bit          ehit;
    int          n;
    exp_q.delete();
    model_access(w, b, a, d, erd, ehit);
    @(negedge clk);
    act_q.delete();
    req_cycles = 0;
    re = r; we = w; byte_addr = b; addr = a; wdata = d;
    #1;
    n = 0;
    while (stall !== 1'b0 && n < 500) begin
      n++;
      @(negedge clk);
      #1;
    end
    if (n >= 500) check_eq("stall_timeout", 32'(stall), 32'd0);
    stall_cyc = n;
    if (r && !w) check_eq("rdata", rdata, erd);
    if (ehit) check_eq("hit_stall_cycles", 32'(n), 32'd0);
    else      check_eq("miss_stall_cycles", 32'(n), 32'(req_cycles));
    @(negedge clk);
    re = 1'b0; we = 1'b0; byte_addr = 1'b0;
    #1;
    check_eq("hit_count",  hit_count,  32'(exp_hits));
    check_eq("miss_count", miss_count, 32'(exp_miss));
    check_eq("beat_total", 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      check_eq("beat_we",   32'(act_q[i].we), 32'(exp_q[i].we));
      check_eq("beat_addr", act_q[i].addr, exp_q[i].addr);
      check_eq("beat_data", act_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          sc;
    int          n;
    logic [31:0] a;
    int          op;

    rst = 1'b0; re = 1'b0; we = 1'b0; byte_addr = 1'b0;
    addr = '0; wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      bk_mem[32'h100 + 32'(4*i)]  = 32'(8'h11 * (i + 1));
      ref_mem[32'h100 + 32'(4*i)] = 32'(8'h11 * (i + 1));
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_stall",      32'(stall),   32'd0);
    check_eq("rst_mem_req",    32'(mem_req), 32'd0);
    check_eq("rst_mem_we",     32'(mem_we),  32'd0);
    check_eq("rst_hit_count",  hit_count,    32'd0);
    check_eq("rst_miss_count", miss_count,   32'd0);
    check_eq("rst_rdata",      rdata,        32'd0);

    // Cold miss, two wait states per beat.
    wait_mode = 2;
    do_access(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, sc);
    check_eq("cold_stall_len", 32'(sc), 32'd12);
    check_eq("cold_miss_cnt", miss_count, 32'd1);
    check_eq("cold_hit_cnt",  hit_count,  32'd0);

    do_access(1'b1, 1'b0, 1'b0, 32'h0000_0108, 32'h0, sc);
    do_access(1'b0, 1'b1, 1'b1, 32'h0000_0105, 32'hABCD_EF5A, sc);
    do_access(1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0, sc);
    do_access(1'b1, 1'b0, 1'b1, 32'h0000_0105, 32'h0, sc);

    // Dirty victim eviction with a long stall on one refill beat.
    wait_mode = 0;
    hold_en   = 1'b1;
    hold_addr = 32'h0000_0508;
    do_access(1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0, sc);
    check_eq("hold_stall_len", 32'(sc), 32'd13);
    hold_en = 1'b0;

    // Reset during the third refill beat.
    wait_mode = 2;
    @(negedge clk);
    act_q.delete();
    re = 1'b1; addr = 32'h0000_0900;
    n = 0;
    while (act_q.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_mid_beats_done", 32'(act_q.size()), 32'd2);
    rst = 1'b0; re = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_mem_req",  32'(mem_req), 32'd0);
    check_eq("rst_mid_stall",    32'(stall),   32'd0);
    check_eq("rst_mid_hit_cnt",  hit_count,    32'd0);
    check_eq("rst_mid_miss_cnt", miss_count,   32'd0);
    model_reset();
    do_access(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, sc);

    // Randomized traffic over a few conflicting sets.
    wait_mode = -1;
    for (int k = 0; k < 200; k++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(14, 17)) << 4)
        | (32'($urandom_range(0, 3)) << 2)  | 32'($urandom_range(0, 3));
      op = int'($urandom_range(0, 99));
      if (op < 40)      do_access(1'b1, 1'b0, 1'b0, a, 32'h0, sc);
      else if (op < 60) do_access(1'b1, 1'b0, 1'b1, a, 32'h0, sc);
      else if (op < 80) do_access(1'b0, 1'b1, 1'b0, a, $urandom, sc);
      else if (op < 95) do_access(1'b0, 1'b1, 1'b1, a, $urandom, sc);
      else              do_access(1'b1, 1'b1, op[0], a, $urandom, sc);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        #1;
        check_eq("idle_stall",   32'(stall),   32'd0);
        check_eq("idle_mem_req", 32'(mem_req), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_data_cache
`default_nettype wire
